// File: rtl/rng_share_array_ext.sv
// Shared random-number source: one RWID-bit sequence (bit-reversed or linear) feeds
// TDIM registered buffers with per-buffer stride, each fanned out to SDIM consumers.
module rng_share_array_ext #(
    parameter  int RWID   = 8,
    parameter  int BDIM   = 4,
    parameter  int SDIM   = 8,
    parameter  int STRIDE = 0,
    localparam int TDIM   = (BDIM < 1) ? 1 : BDIM
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            clear,
    input  logic            seqMode,
    output logic [RWID-1:0] rngSeq [TDIM*SDIM],
    output logic            rngValid,
    output logic            periodDone
);

    logic [RWID-1:0] cnt_q, cnt_d;
    logic [RWID-1:0] rev, base;
    logic [RWID-1:0] buf_q [TDIM];
    logic            valid_q, done_q;

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (enable) cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        rev = '0;
        for (int k = 0; k < RWID; k++) rev[k] = cnt_q[RWID-1-k];
        base = seqMode ? cnt_q : rev;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            // NOTE: the buffer array is reset because consumers must read zeros during reset.
            for (int i = 0; i < TDIM; i++) buf_q[i] <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= enable & ~clear;
            done_q  <= enable & ~clear & (cnt_q == '1);
            // Stride offset is a constant per buffer, truncated to RWID bits.
            for (int i = 0; i < TDIM; i++) buf_q[i] <= base + RWID'(i * STRIDE);
        end
    end

    for (genvar i = 0; i < TDIM; i++) begin : g_buf
        for (genvar j = 0; j < SDIM; j++) begin : g_fan
            assign rngSeq[i*SDIM+j] = buf_q[i];
        end
    end

    assign rngValid   = valid_q;
    assign periodDone = done_q;

endmodule
